// File: rtl/dac_spi_receiver.sv
// Receives 16-bit DAC command frames from an asynchronous SPI-style bus into clk100.
// Optional shutdown handling is compiled in with DAC_RX_SHDN_EN.
module dac_spi_receiver #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk100,
    input  logic        rst_n,
    input  logic        cs,
    input  logic        sclk,
    input  logic        sdi,
    input  logic        ldac,
    output logic [11:0] out_a,
    output logic [11:0] out_b,
    output logic        update,
    output logic        shdn_a,
    output logic        shdn_b,
    output logic        frame_err,
    output logic [15:0] frame_cnt
);

    typedef enum logic [1:0] {
        WAIT_HIGH = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, sdi_sync, ldac_sync;
    logic                   cs_d, sclk_d, sdi_d, ldac_d;
    logic                   cs_fall, cs_rise, sclk_rise, ldac_fall;

    logic        start, shift_en, accept, reject;
    logic [15:0] shreg;
    logic [4:0]  bit_cnt;

    logic [11:0] in_a_data, in_b_data, nxt_a_data, nxt_b_data;
    logic        in_a_on, in_b_on, nxt_a_on, nxt_b_on;

    // Edge events are registered, so the *_d levels line up with the event cycle.
    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync   <= '0;
            sclk_sync <= '0;
            sdi_sync  <= '0;
            ldac_sync <= '0;
            cs_d      <= 1'b0;
            sclk_d    <= 1'b0;
            sdi_d     <= 1'b0;
            ldac_d    <= 1'b0;
            cs_fall   <= 1'b0;
            cs_rise   <= 1'b0;
            sclk_rise <= 1'b0;
            ldac_fall <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi};
            ldac_sync <= {ldac_sync[SYNC_STAGES-2:0], ldac};
            cs_d      <= cs_sync[SYNC_STAGES-1];
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            sdi_d     <= sdi_sync[SYNC_STAGES-1];
            ldac_d    <= ldac_sync[SYNC_STAGES-1];
            cs_fall   <= cs_d & ~cs_sync[SYNC_STAGES-1];
            cs_rise   <= ~cs_d & cs_sync[SYNC_STAGES-1];
            sclk_rise <= ~sclk_d & sclk_sync[SYNC_STAGES-1];
            ldac_fall <= ldac_d & ~ldac_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) state <= WAIT_HIGH;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_HIGH: if (cs_d)    state_nxt = IDLE;
            IDLE:      if (cs_fall) state_nxt = SHIFT;
            SHIFT:     if (cs_rise) state_nxt = IDLE;
            default:                state_nxt = WAIT_HIGH;
        endcase
    end

    always_comb begin
        start    = 1'b0;
        shift_en = 1'b0;
        accept   = 1'b0;
        reject   = 1'b0;
        case (state)
            IDLE:  start = cs_fall;
            SHIFT: begin
                shift_en = sclk_rise & ~cs_rise;
                accept   = cs_rise & (bit_cnt == 5'd16);
                reject   = cs_rise & (bit_cnt != 5'd16);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk100) begin
        if (start)         shreg <= '0;
        else if (shift_en) shreg <= {shreg[14:0], sdi_d};
    end

    // Counter saturates at 17 so over-long frames stay distinguishable from 16.
    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
        end else if (start) begin
            bit_cnt <= '0;
        end else if (shift_en && bit_cnt != 5'd17) begin
            bit_cnt <= bit_cnt + 5'd1;
        end
    end

    always_comb begin
        nxt_a_data = in_a_data;
        nxt_a_on   = in_a_on;
        nxt_b_data = in_b_data;
        nxt_b_on   = in_b_on;
        if (accept) begin
            if (shreg[15]) begin
                nxt_b_data = shreg[11:0];
                nxt_b_on   = shreg[12];
            end else begin
                nxt_a_data = shreg[11:0];
                nxt_a_on   = shreg[12];
            end
        end
    end

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            in_a_data <= '0;
            in_a_on   <= 1'b0;
            in_b_data <= '0;
            in_b_on   <= 1'b0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
            update    <= 1'b0;
        end else begin
            in_a_data <= nxt_a_data;
            in_a_on   <= nxt_a_on;
            in_b_data <= nxt_b_data;
            in_b_on   <= nxt_b_on;
            frame_err <= reject;
            update    <= ldac_fall;
            if (accept) frame_cnt <= frame_cnt + 16'd1;
        end
    end

    // Loads use the next-state input registers so a same-cycle accept is forwarded.
`ifdef DAC_RX_SHDN_EN
    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            out_a  <= '0;
            out_b  <= '0;
            shdn_a <= 1'b0;
            shdn_b <= 1'b0;
        end else if (ldac_fall) begin
            shdn_a <= ~nxt_a_on;
            shdn_b <= ~nxt_b_on;
            out_a  <= nxt_a_on ? nxt_a_data : 12'h000;
            out_b  <= nxt_b_on ? nxt_b_data : 12'h000;
        end
    end

    logic unused_bits;
    assign unused_bits = ^shreg[14:13];
`else
    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            out_a <= '0;
            out_b <= '0;
        end else if (ldac_fall) begin
            out_a <= nxt_a_data;
            out_b <= nxt_b_data;
        end
    end

    assign shdn_a = 1'b0;
    assign shdn_b = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{shreg[14:13], nxt_a_on, nxt_b_on};
`endif

endmodule

// File: doc/dac_spi_receiver.md
DAC_SPI_RECEIVER -- requirements
Module: dac_spi_receiver

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the input synchronizer depth (minimum 2).
REQ-002 SHALL have port clk100, input, 1 bit: the single system clock (100 MHz).
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have ports cs, sclk, sdi, ldac, each input, 1 bit: DAC serial bus pins, asynchronous to clk100.
REQ-005 SHALL have ports out_a and out_b, each output, 12 bits: latched DAC channel words.
REQ-006 SHALL have port update, output, 1 bit: one-cycle pulse when out_a/out_b are loaded.
REQ-007 SHALL have ports shdn_a and shdn_b, each output, 1 bit: channel shutdown flags.
REQ-008 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a malformed frame.
REQ-009 SHALL have port frame_cnt, output, 16 bits: count of accepted frames, wrapping.

Function
REQ-010 SHALL pass cs, sclk, sdi and ldac through SYNC_STAGES flops each, then one edge-detect register.
REQ-011 SHALL support sclk up to clk100/4; behaviour at faster sclk is unspecified.
REQ-012 SHALL use FSM states WAIT_HIGH, IDLE and SHIFT; WAIT_HIGH moves to IDLE when synced cs=1.
REQ-013 SHALL move from IDLE to SHIFT on the synced cs falling edge, clearing the 16-bit shift register and the 5-bit bit counter.
REQ-014 SHALL, in SHIFT, shift synced sdi in MSB-first on each synced sclk rising edge; the bit counter saturates at 17.
REQ-015 SHALL, on the synced cs rising edge in SHIFT, accept the frame if the count is exactly 16, otherwise pulse frame_err and discard the frame; the FSM then returns to IDLE.
REQ-016 SHALL decode an accepted frame as: bit15 channel (0=A, 1=B), bit14 BUF (ignored), bit13 GA_n (ignored), bit12 SHDN_n, bits11:0 data.
REQ-017 SHALL write an accepted frame into the selected channel's input register (data plus SHDN_n), increment frame_cnt (0xFFFF wraps to 0x0000), and leave the outputs unchanged.
REQ-018 SHALL, on a synced ldac falling edge, copy both input registers to the outputs on the next clk100 edge and pulse update high for exactly that cycle.
REQ-019 SHALL ignore an ldac level held low; only falling edges load.
REQ-020 SHALL, when frame acceptance and an ldac falling edge occur in the same cycle, forward the new frame's contents into the load.
REQ-021 SHALL make the latency from the ldac pin falling to update high equal SYNC_STAGES+2 clk100 cycles.
REQ-022 SHALL keep the input register contents across rejected frames.

Reset
REQ-023 SHALL, while rst_n=0, clear immediately: out_a=0, out_b=0, update=0, shdn_a=0, shdn_b=0, frame_err=0, frame_cnt=0, input registers=0, synchronizers=0, state=WAIT_HIGH.
REQ-024 SHALL, if rst_n is asserted mid-frame, lose that frame; after release, no frame is accepted until cs has been observed high.

Configuration
REQ-025 SHALL, when DAC_RX_SHDN_EN is defined, on load set shdn_x = ~SHDN_n of that channel's input register, and force out_x to 0 while shdn_x=1.
REQ-026 SHALL, when DAC_RX_SHDN_EN is undefined, ignore SHDN_n: shdn_a and shdn_b are tied 0 and out_x always takes the data field.

Verification
REQ-027 SHALL cover: frame 0x3ABC followed by an ldac low pulse -> out_a=0xABC, out_b=0x000, one update pulse, frame_cnt=1.
REQ-028 SHALL cover: frames 0x3123 and 0xBFED, then one ldac pulse -> out_a=0x123 and out_b=0xFED updating in the same cycle, frame_cnt=2.
REQ-029 SHALL cover: a 15-bit frame and a 17-bit frame -> two frame_err pulses, frame_cnt unchanged, next ldac reloads the previous values.
REQ-030 SHALL cover: rst_n low after 8 bits of frame 0x3FFF -> all outputs 0; after release with cs still low, the remaining bits are ignored; the next full frame 0x3001 plus ldac -> out_a=0x001.
REQ-031 SHALL cover: frame 0x2555 plus ldac -> with DAC_RX_SHDN_EN shdn_a=1 and out_a=0; without it shdn_a=0 and out_a=0x555.
REQ-032 SHALL cover: cs rise and ldac fall aligned on the same cycle with frame 0x3777 -> out_a=0x777 within SYNC_STAGES+2 cycles.
